// File: rtl/polar_clip_div_32s_16s_16_seq_if.sv
// Handshake bundle for the polar_clip sequential divider.
// The master drives operands and result acceptance; the slave is the divider.
interface polar_clip_div_32s_16s_16_seq_if #(
    parameter int DIVIDEND_WIDTH = 32,
    parameter int DIVISOR_WIDTH  = 16
);
    // Operand side
    logic                             in_valid;
    logic                             in_ready;
    logic signed [DIVIDEND_WIDTH-1:0] dividend;
    logic signed [DIVISOR_WIDTH-1:0]  divisor;

    // Result side
    logic                             out_valid;
    logic                             out_ready;
    logic signed [DIVISOR_WIDTH-1:0]  quotient;
    logic signed [DIVISOR_WIDTH-1:0]  remainder;
    logic                             ovf;
    logic                             dbz;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, ovf, dbz
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, ovf, dbz
    );
endinterface

// File: rtl/polar_clip_div_32s_16s_16_seq.sv
// Iterative signed divider, 32s / 16s -> saturated 16s quotient + 16s remainder.
// Radix-2 restoring on magnitudes, one quotient bit per enabled clock, signs and
// saturation applied when the last bit is produced. One operation in flight.
module polar_clip_div_32s_16s_16_seq #(
    parameter int DIVIDEND_WIDTH = 32,
    parameter int DIVISOR_WIDTH  = 16
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 ce,
    polar_clip_div_32s_16s_16_seq_if.slave       bus
);
    localparam int DW = DIVIDEND_WIDTH;
    localparam int VW = DIVISOR_WIDTH;
    localparam int CW = $clog2(DW);

    // Saturation bounds of the VW-bit signed quotient, held at DW+1 bits so they
    // compare directly against the widened signed quotient.
    localparam logic signed [DW:0] Q_MAX = (DW+1)'(2 ** (VW - 1) - 1);
    localparam logic signed [DW:0] Q_MIN = (DW+1)'(-(2 ** (VW - 1)));

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t               state;
    logic [CW-1:0]        count;

    // Latched operand information
    logic                 q_sign;     // sign of the true quotient
    logic                 r_sign;     // sign of the dividend, carried to the remainder
    logic                 zero_div;   // divisor was zero
    logic [VW-1:0]        dvs_mag;    // |divisor|, unsigned (32768 fits)

    // dvd_q shifts dividend magnitude bits out of the MSB while quotient bits
    // shift in at the LSB; after DW iterations it holds the quotient magnitude.
    logic [DW-1:0]        dvd_q;
    logic [VW-1:0]        part_rem;

    // Registered result
    logic                 in_ready_r;
    logic                 out_valid_r;
    logic signed [VW-1:0] quotient_r;
    logic signed [VW-1:0] remainder_r;
    logic                 ovf_r;
    logic                 dbz_r;

    // Operand magnitudes; negating the most negative value wraps to the correct
    // unsigned magnitude (2^(W-1)).
    logic [DW-1:0]        dvd_mag;
    logic [VW-1:0]        dvs_mag_in;

    assign dvd_mag    = bus.dividend[DW-1] ? -bus.dividend : bus.dividend;
    assign dvs_mag_in = bus.divisor[VW-1]  ? -bus.divisor  : bus.divisor;

    // One restoring step plus the final sign/saturation stage.
    logic [VW:0]          shifted;
    logic [VW+1:0]        trial;
    logic                 q_bit;
    logic [VW-1:0]        rem_next;
    logic [DW-1:0]        q_mag_next;
    logic signed [DW:0]   q_wide;
    logic signed [VW-1:0] q_final;
    logic signed [VW-1:0] r_final;
    logic                 ovf_final;
    logic                 unused_bits;

    // Combinational iteration step and result formatting
    always_comb begin
        // NOTE: every always_comb output is assigned a default first so no path can infer a latch.
        q_final   = '0;
        r_final   = '0;
        ovf_final = 1'b0;

        // The partial remainder is always below |divisor| <= 2^(VW-1), so the
        // shifted value fits VW+1 bits and the trial needs one extra sign bit.
        shifted    = {part_rem, dvd_q[DW-1]};
        trial      = {1'b0, shifted} - {2'b00, dvs_mag};
        q_bit      = ~trial[VW+1];
        rem_next   = q_bit ? trial[VW-1:0] : shifted[VW-1:0];
        q_mag_next = {dvd_q[DW-2:0], q_bit};

        // Signed quotient at DW+1 bits so 2^(DW-1) is representable either way.
        q_wide = q_sign ? -$signed({1'b0, q_mag_next}) : $signed({1'b0, q_mag_next});

        if (zero_div) begin
            q_final   = r_sign ? {1'b1, {(VW-1){1'b0}}} : {1'b0, {(VW-1){1'b1}}};
            r_final   = '0;
            ovf_final = 1'b0;
        end else if (q_wide > Q_MAX) begin
            q_final   = {1'b0, {(VW-1){1'b1}}};
            r_final   = r_sign ? -rem_next : rem_next;
            ovf_final = 1'b1;
        end else if (q_wide < Q_MIN) begin
            q_final   = {1'b1, {(VW-1){1'b0}}};
            r_final   = r_sign ? -rem_next : rem_next;
            ovf_final = 1'b1;
        end else begin
            q_final   = q_wide[VW-1:0];
            r_final   = r_sign ? -rem_next : rem_next;
            ovf_final = 1'b0;
        end
    end

    // Top bits of the trial and shifted words are never needed once q_bit is known.
    assign unused_bits = ^{trial[VW], shifted[VW]};

    // Control FSM and datapath registers, all frozen while ce is low
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: datapath and result registers are reset as well, because an abort must return every output to its idle value.
        if (reset) begin
            state       <= IDLE;
            count       <= '0;
            q_sign      <= 1'b0;
            r_sign      <= 1'b0;
            zero_div    <= 1'b0;
            dvs_mag     <= '0;
            dvd_q       <= '0;
            part_rem    <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            quotient_r  <= '0;
            remainder_r <= '0;
            ovf_r       <= 1'b0;
            dbz_r       <= 1'b0;
        end else if (ce) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_r) begin
                        q_sign     <= bus.dividend[DW-1] ^ bus.divisor[VW-1];
                        r_sign     <= bus.dividend[DW-1];
                        zero_div   <= (bus.divisor == '0);
                        dvs_mag    <= dvs_mag_in;
                        dvd_q      <= dvd_mag;
                        part_rem   <= '0;
                        count      <= '0;
                        in_ready_r <= 1'b0;
                        state      <= CALC;
                    end
                end

                CALC: begin
                    dvd_q    <= q_mag_next;
                    part_rem <= rem_next;
                    count    <= count + 1'b1;
                    if (count == CW'(DW - 1)) begin
                        quotient_r  <= q_final;
                        remainder_r <= r_final;
                        ovf_r       <= ovf_final;
                        dbz_r       <= zero_div;
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end
                end

                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end

                default: begin
                    state       <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.quotient  = quotient_r;
    assign bus.remainder = remainder_r;
    assign bus.ovf       = ovf_r;
    assign bus.dbz       = dbz_r;

endmodule
